// File: rtl/pipelined_adder4.sv
// Two-stage registered adder: operand register, then sum register.
// Optional clamp to all-ones when the sum overflows.
module pipelined_adder4 #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_da;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_f;

  // Extra bit holds the carry; it only matters for the clamp.
  assign w_sum = {1'b0, r_da} + {1'b0, r_db};

  always_comb begin
    w_f = w_sum[WIDTH-1:0];
    if (SATURATE && w_sum[WIDTH])
      w_f = '1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_da <= '0;
      r_db <= '0;
      r_q  <= '0;
    end else begin
      r_da <= DA;
      r_db <= DB;
      r_q  <= w_f;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_pipelined_adder4.sv
// Scoreboard bench for pipelined_adder4, wrap and saturate builds
// driven side by side from the same operands.
module tb_pipelined_adder4;

  typedef struct {
    logic [3:0] w;
    logic [3:0] s;
  } exp_t;

  logic       CLK;
  logic       RSTN;
  logic [3:0] DA;
  logic [3:0] DB;
  logic [3:0] q_w;
  logic [3:0] q_s;

  int n_chk;
  int n_pass;
  exp_t sb[$];

  pipelined_adder4 #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RSTN(RSTN), .DA(DA), .DB(DB), .Q(q_w)
  );

  pipelined_adder4 #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .DA(DA), .DB(DB), .Q(q_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [3:0] a,
                                 input logic [3:0] b);
    exp_t e;
    logic [4:0] s;
    s   = {1'b0, a} + {1'b0, b};
    e.w = s[3:0];
    e.s = s[4] ? 4'hF : s[3:0];
    return e;
  endfunction

  // Drive a pair, take one edge, compare Q against the pair
  // sampled on the previous edge.
  task automatic step(input logic [3:0] a,
                      input logic [3:0] b,
                      input string tag);
    exp_t e;
    DA = a;
    DB = b;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got %h", tag, q_w);
    end else begin
      e = sb.pop_front();
      chk({tag, "_wrap"}, q_w, e.w);
      chk({tag, "_sat"},  q_s, e.s);
    end
    sb.push_back(model(a, b));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    RSTN   = 1'b0;
    DA     = 4'hF;
    DB     = 4'h1;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wrap", q_w, 4'h0);
    chk("rst_sat",  q_s, 4'h0);

    #3;
    RSTN = 1'b1;
    sb.push_back(model(4'h0, 4'h0));

    step(4'h3, 4'h4, "basic_pre");
    step(4'hF, 4'h2, "basic");
    step(4'h8, 4'h8, "wrap_f2");
    step(4'hC, 4'h9, "wrap_88");
    step(4'h7, 4'h8, "sat_c9");
    step(4'h1, 4'h1, "sat_78");
    step(4'h2, 4'h3, "str_11");
    step(4'h5, 4'h5, "str_23");
    step(4'hF, 4'h0, "str_55");

    #2;
    RSTN = 1'b0;
    #1;
    chk("aclr_wrap", q_w, 4'h0);
    chk("aclr_sat",  q_s, 4'h0);

    @(posedge CLK);
    #1;
    chk("hold_wrap", q_w, 4'h0);
    chk("hold_sat",  q_s, 4'h0);

    #2;
    RSTN = 1'b1;
    sb.delete();
    sb.push_back(model(4'h0, 4'h0));
    #1;
    chk("rel_wrap", q_w, 4'h0);

    step(4'h6, 4'h1, "post1");
    step(4'h0, 4'h0, "post2");
    step(4'h0, 4'h0, "drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
